// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: widths, opcodes and the decoded bundle types for the decode stage
package decode_stage_pkg;
  localparam int ARCH_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALU_I = 7'b0010011;
  localparam logic [6:0] OPC_ALU_R = 7'b0110011;
  typedef enum logic [3:0] {
    OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ILLEGAL
  } decoded_op_t;
  typedef struct packed {
    logic valid;
    logic [ARCH_LEN-1:0] pc;
    logic [INST_LEN-1:0] inst;
  } if_id_t;
endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 32x32 integer registers, two read ports, one write port, x0 hardwired, write-through bypass
module regfile
  import decode_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] ra1_i,
  input  logic [REG_ADDR_LEN-1:0] ra2_i,
  output logic [ARCH_LEN-1:0]     rd1_o,
  output logic [ARCH_LEN-1:0]     rd2_o,
  input  logic                    we_i,
  input  logic [REG_ADDR_LEN-1:0] wa_i,
  input  logic [ARCH_LEN-1:0]     wd_i
);
  logic [ARCH_LEN-1:0] regs_q [32];
  // clear on reset, otherwise commit writeback (x0 never written)
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    else if (we_i && wa_i != '0) regs_q[wa_i] <= wd_i;
  end
  // reads see a same-cycle write so writeback needs no extra forwarding
  always_comb begin
    rd1_o = ra1_i == '0 ? '0 : (we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
    rd2_o = ra2_i == '0 ? '0 : (we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, RV32I decode, register read and load-use hazard detection
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INST_LEN-1:0]     inst_in,
  input  logic [ARCH_LEN-1:0]     pc_in,
  input  logic                    stall_in,
  input  logic                    flush_in,
  input  logic                    ex_is_load_in,
  input  logic [REG_ADDR_LEN-1:0] ex_rd_in,
  input  logic                    wb_en_in,
  input  logic [REG_ADDR_LEN-1:0] wb_rd_in,
  input  logic [ARCH_LEN-1:0]     wb_data_in,
  output logic                    stall_fet_out,
  output logic                    valid_out,
  output logic [ARCH_LEN-1:0]     pc_out,
  output decoded_op_t             op_out,
  output logic [2:0]              funct3_out,
  output logic                    funct7b5_out,
  output logic [REG_ADDR_LEN-1:0] rs1_out,
  output logic [REG_ADDR_LEN-1:0] rs2_out,
  output logic [REG_ADDR_LEN-1:0] rd_out,
  output logic [ARCH_LEN-1:0]     rs1_data_out,
  output logic [ARCH_LEN-1:0]     rs2_data_out,
  output logic [ARCH_LEN-1:0]     imm_out,
  output logic                    illegal_out
);
  if_id_t if_id_q, if_id_d;
  logic [INST_LEN-1:0] i;
  logic uses_rs1, uses_rs2, has_rd, hazard;
  assign i = if_id_q.inst;
  // IF/ID: reset and flush load a NOP bubble; stall and hazard hold
  always_comb begin
    if_id_d = (rst || flush_in) ? '{valid: 1'b0, pc: '0, inst: NOP_INST} :
              (stall_in || hazard) ? if_id_q : '{valid: 1'b1, pc: pc_in, inst: inst_in};
  end
  // IF/ID register
  always_ff @(posedge clk) if_id_q <= if_id_d;
  // classify opcode into the execute-facing instruction class
  always_comb begin
    case (i[6:0])
      OPC_ALU_R:  op_out = OP_ALU_R;
      OPC_ALU_I:  op_out = OP_ALU_I;
      OPC_LOAD:   op_out = OP_LOAD;
      OPC_STORE:  op_out = OP_STORE;
      OPC_BRANCH: op_out = OP_BRANCH;
      OPC_JAL:    op_out = OP_JAL;
      OPC_JALR:   op_out = OP_JALR;
      OPC_LUI:    op_out = OP_LUI;
      OPC_AUIPC:  op_out = OP_AUIPC;
      default:    op_out = OP_ILLEGAL;
    endcase
  end
  // operand usage, immediate assembly and hazard check
  always_comb begin
    uses_rs1 = !(op_out inside {OP_LUI, OP_AUIPC, OP_JAL});
    uses_rs2 = op_out inside {OP_ALU_R, OP_STORE, OP_BRANCH};
    has_rd = !(op_out inside {OP_STORE, OP_BRANCH, OP_ILLEGAL});
    imm_out = (op_out inside {OP_LOAD, OP_ALU_I, OP_JALR}) ? {{20{i[31]}}, i[31:20]} :
              op_out == OP_STORE  ? {{20{i[31]}}, i[31:25], i[11:7]} :
              op_out == OP_BRANCH ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
              (op_out inside {OP_LUI, OP_AUIPC}) ? {i[31:12], 12'h000} :
              op_out == OP_JAL    ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : '0;
    hazard = if_id_q.valid && ex_is_load_in && ex_rd_in != '0 &&
             ((uses_rs1 && ex_rd_in == i[19:15]) || (uses_rs2 && ex_rd_in == i[24:20]));
  end
  assign stall_fet_out = (hazard || stall_in) && !rst && !flush_in;
  assign valid_out = if_id_q.valid && !hazard;
  assign illegal_out = valid_out && op_out == OP_ILLEGAL;
  assign pc_out = if_id_q.pc;
  assign funct3_out = i[14:12];
  assign funct7b5_out = i[30];
  assign rs1_out = i[19:15];
  assign rs2_out = i[24:20];
  assign rd_out = has_rd ? i[11:7] : '0;
  regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs1_out),
    .ra2_i (rs2_out),
    .rd1_o (rs1_data_out),
    .rd2_o (rs2_data_out),
    .we_i  (wb_en_in),
    .wa_i  (wb_rd_in),
    .wd_i  (wb_data_in)
  );
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for the decode stage with hand-computed expectations
module tb_decode_stage;
  import decode_stage_pkg::*;
  logic clk = 0, rst = 1;
  logic [31:0] inst_in = NOP_INST, pc_in = '0, wb_data_in = '0;
  logic stall_in = 0, flush_in = 0, ex_is_load_in = 0, wb_en_in = 0;
  logic [4:0] ex_rd_in = '0, wb_rd_in = '0;
  logic stall_fet_out, valid_out, funct7b5_out, illegal_out;
  logic [31:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
  decoded_op_t op_out;
  logic [2:0] funct3_out;
  logic [4:0] rs1_out, rs2_out, rd_out;
  int n_run = 0, n_fail = 0;
  decode_stage dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .pc_in(pc_in), .stall_in(stall_in),
    .flush_in(flush_in), .ex_is_load_in(ex_is_load_in), .ex_rd_in(ex_rd_in),
    .wb_en_in(wb_en_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .stall_fet_out(stall_fet_out), .valid_out(valid_out), .pc_out(pc_out), .op_out(op_out),
    .funct3_out(funct3_out), .funct7b5_out(funct7b5_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rd_out(rd_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .imm_out(imm_out), .illegal_out(illegal_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    rst = 0;
    check("rst_valid", 32'(valid_out), 0);
    check("rst_pc", pc_out, 0);
    check("rst_op", 32'(op_out), 32'(OP_ALU_I));
    check("rst_imm", imm_out, 0);
    check("rst_rd", 32'(rd_out), 0);
    check("rst_stall", 32'(stall_fet_out), 0);
    check("rst_illegal", 32'(illegal_out), 0);
    inst_in = 32'h0050_0093; pc_in = 0;
    step();
    check("addi_valid", 32'(valid_out), 1);
    check("addi_op", 32'(op_out), 32'(OP_ALU_I));
    check("addi_rd", 32'(rd_out), 1);
    check("addi_rs1", 32'(rs1_out), 0);
    check("addi_imm", imm_out, 5);
    stall_in = 1; wb_en_in = 1; wb_rd_in = 0; wb_data_in = 32'h1234;
    #1 check("x0_bypass", rs1_data_out, 0);
    check("stall_fet_stall", 32'(stall_fet_out), 1);
    step();
    check("x0_after_write", rs1_data_out, 0);
    stall_in = 0; wb_en_in = 0; inst_in = 32'h0021_01B3; pc_in = 4;
    step();
    check("add_op", 32'(op_out), 32'(OP_ALU_R));
    stall_in = 1; wb_en_in = 1; wb_rd_in = 2; wb_data_in = 32'hDEAD_BEEF;
    #1 check("bypass_rs1", rs1_data_out, 32'hDEAD_BEEF);
    check("bypass_rs2", rs2_data_out, 32'hDEAD_BEEF);
    step();
    wb_en_in = 0;
    #1 check("stored_x2", rs2_data_out, 32'hDEAD_BEEF);
    check("add_pc_held", pc_out, 4);
    stall_in = 0; inst_in = 32'h0053_2423; pc_in = 8;
    step();
    ex_is_load_in = 1; ex_rd_in = 5; inst_in = NOP_INST; pc_in = 12;
    #1 check("haz_stall", 32'(stall_fet_out), 1);
    check("haz_bubble", 32'(valid_out), 0);
    wb_en_in = 1; wb_rd_in = 6; wb_data_in = 32'h55;
    step();
    wb_en_in = 0;
    check("haz_held_pc", pc_out, 8);
    check("haz_still", 32'(stall_fet_out), 1);
    ex_is_load_in = 0;
    #1 check("sw_valid", 32'(valid_out), 1);
    check("sw_op", 32'(op_out), 32'(OP_STORE));
    check("sw_imm", imm_out, 8);
    check("sw_rd", 32'(rd_out), 0);
    check("sw_nostall", 32'(stall_fet_out), 0);
    check("sw_wb_in_hazard", rs1_data_out, 32'h55);
    inst_in = 32'hFE20_88E3; pc_in = 32'h10;
    step();
    check("beq_op", 32'(op_out), 32'(OP_BRANCH));
    check("beq_imm", imm_out, 32'hFFFF_FFF0);
    flush_in = 1;
    step();
    flush_in = 0;
    check("flush_valid", 32'(valid_out), 0);
    check("flush_pc", pc_out, 0);
    step();
    check("beq_again", 32'(op_out), 32'(OP_BRANCH));
    ex_is_load_in = 1; ex_rd_in = 2; flush_in = 1;
    #1 check("flush_haz_nostall", 32'(stall_fet_out), 0);
    step();
    flush_in = 0; ex_is_load_in = 0;
    check("flush_haz_bubble", 32'(valid_out), 0);
    inst_in = 32'hFFDF_F0EF; pc_in = 32'h20;
    step();
    check("jal_op", 32'(op_out), 32'(OP_JAL));
    check("jal_imm", imm_out, 32'hFFFF_FFFC);
    check("jal_rd", 32'(rd_out), 1);
    inst_in = 32'hFFFF_F3B7; pc_in = 32'h24;
    step();
    ex_is_load_in = 1; ex_rd_in = 31;
    #1 check("lui_imm", imm_out, 32'hFFFF_F000);
    check("lui_nohaz", 32'(stall_fet_out), 0);
    check("lui_valid", 32'(valid_out), 1);
    check("lui_rd", 32'(rd_out), 7);
    ex_is_load_in = 0;
    inst_in = 32'h0000_007F; pc_in = 32'h30;
    step();
    check("illegal", 32'(illegal_out), 1);
    check("illegal_op", 32'(op_out), 32'(OP_ILLEGAL));
    stall_in = 1; inst_in = 32'h0050_0093; pc_in = 32'h34;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall3_fet", 32'(stall_fet_out), 1);
      check("stall3_pc", pc_out, 32'h30);
      check("stall3_ill", 32'(illegal_out), 1);
      step();
    end
    stall_in = 0;
    step();
    check("after_stall_pc", pc_out, 32'h34);
    check("after_stall_ill", 32'(illegal_out), 0);
    stall_in = 1; rst = 1;
    step();
    rst = 0; stall_in = 0;
    check("rst_mid_valid", 32'(valid_out), 0);
    check("rst_mid_stall", 32'(stall_fet_out), 0);
    check("rst_mid_x2", rs2_data_out, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the RV32I core: captures the instruction and PC from the fetch stage into the IF/ID register, decodes them, reads the 32x32 integer register file and presents a decoded bundle to execute. Owns the register file write port driven by writeback. Detects load-use hazards and back-pressures fetch through `stall_fet_out`. Applies control-flow flushes from execute.

## Interface
Parameters:
- None. Widths come from `constants_pkg`: `ARCH_LEN`=32, `INST_LEN`=32, `REG_ADDR_LEN`=5.

Ports:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `inst_in`  in  INST_LEN  instruction from fetch; NOP (0x00000013) when fetch is stalled or missing.
- `pc_in`  in  ARCH_LEN  PC of `inst_in`.
- `stall_in`  in  1  execute cannot accept; hold everything.
- `flush_in`  in  1  taken branch/jump resolved in execute; squash IF/ID.
- `ex_is_load_in`  in  1  instruction currently in execute is a load.
- `ex_rd_in`  in  REG_ADDR_LEN  destination of that instruction.
- `wb_en_in`  in  1  register write enable from writeback.
- `wb_rd_in`  in  REG_ADDR_LEN  write address.
- `wb_data_in`  in  ARCH_LEN  write data.
- `stall_fet_out`  out  1  freezes fetch PC; drives fetch `stall_fet_in`.
- `valid_out`  out  1  bundle below is a real instruction.
- `pc_out`  out  ARCH_LEN  PC of decoded instruction.
- `op_out`  out  `decoded_op_t`  instruction class.
- `funct3_out`  out  3  raw funct3.
- `funct7b5_out`  out  1  inst[30].
- `rs1_out`, `rs2_out`, `rd_out`  out  REG_ADDR_LEN  register indices; `rd_out`=0 when the class has no destination.
- `rs1_data_out`, `rs2_data_out`  out  ARCH_LEN  register file read data.
- `imm_out`  out  ARCH_LEN  sign-extended immediate.
- `illegal_out`  out  1  unknown opcode in a valid slot.

## Operation
- IF/ID register: {inst, pc}. On reset it loads {0x00000013, 0}.
- Update priority, evaluated at each rising edge:
  1. `rst`
  2. `flush_in`: load NOP, pc 0, valid 0
  3. `stall_in`: hold
  4. load-use hazard: hold
  5. otherwise: load {`inst_in`, `pc_in`}, valid 1
- The IF/ID valid bit is 0 on reset and after a flush. A fetched NOP is decoded as a valid `OP_ALU_I`.
- Decode is combinational from IF/ID. Immediate formats, sign bit always inst[31]:
  - I: LOAD, ALU_I, JALR
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC, low 12 bits 0
  - J: JAL, bit0=0
  - Other classes: 0
- Opcodes outside RV32I base give `op_out`=`OP_ILLEGAL` and assert `illegal_out` when valid.
- Register file:
  - x0 reads 0 and ignores writes.
  - Write occurs at the clock edge when `wb_en_in`.
  - Same-cycle read of `wb_rd_in` (nonzero) with `wb_en_in` returns `wb_data_in` (write-through bypass).
  - Reset clears all 32 registers.
- Load-use hazard: `ex_is_load_in` and `ex_rd_in`≠0 and `ex_rd_in` equals a used source of the IF/ID instruction.
  - rs1 is used by all classes except LUI, AUIPC, JAL.
  - rs2 is used by ALU_R, STORE, BRANCH.
- While the hazard holds: `stall_fet_out`=1, IF/ID held, `valid_out`=0 (bubble).
- `stall_fet_out` = hazard OR `stall_in`, and is 0 during `rst` and `flush_in`.
- During `stall_in`, outputs reflect the held IF/ID contents unchanged.

## Timing
- Latency: instruction on `inst_in` at edge N is decoded on outputs during cycle N+1. All outputs are combinational from IF/ID, the register file and WB inputs.
- Reset values, cycle after `rst`: `valid_out`=0, `pc_out`=0, `op_out`=`OP_ALU_I`, all indices/data/imm 0, `illegal_out`=0, `stall_fet_out`=0.
- Flush and hazard in the same cycle: flush wins; bubble next cycle; no stall.
- WB write in the cycle of a hazard stall is still performed.
- Reset mid-stall: IF/ID reset at that edge; stall released the following cycle.

## Structure
- `structure_pkg` additions:
  - `decoded_op_t` enum: ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL.
  - `if_id_t` struct: {valid, pc, inst}.
- `constants_pkg` additions: opcode constants, `NOP_INST`.
- One sub-module: `regfile` (32x32, 2 read / 1 write ports, x0 zero, write-through bypass).

## Test plan
- Reset then `inst_in`=0x00500093 (addi x1,x0,5), `pc_in`=0x0 -> next cycle: `valid_out`=1, `op_out`=ALU_I, `rd_out`=1, `rs1_out`=0, `imm_out`=5.
- Same cycle `wb_en_in`=1, `wb_rd_in`=2, `wb_data_in`=0xDEADBEEF; IF/ID holds add x3,x2,x2 -> `rs1_data_out`=`rs2_data_out`=0xDEADBEEF (bypass). Write x0=0x1234 -> x0 still reads 0.
- `ex_is_load_in`=1, `ex_rd_in`=5, IF/ID holds sw x5,8(x6) -> `stall_fet_out`=1, `valid_out`=0, IF/ID held. Drop the load -> store issues with `imm_out`=8.
- `flush_in`=1 while IF/ID holds beq x1,x2,-16 -> next cycle `valid_out`=0. Same flush with a hazard pending -> `stall_fet_out`=0.
- Immediate sign extension: jal x1,-4 (0xFFDFF0EF) -> `imm_out`=0xFFFFFFFC. lui x7,0xFFFFF -> `imm_out`=0xFFFFF000, rs1 hazard ignored.
- `inst_in`=0x0000007F -> `illegal_out`=1. `stall_in` held 3 cycles -> outputs constant, `stall_fet_out`=1 throughout.
